obj_mover: RTL
==============

Name: obj_mover

Overview:
- Upstream stage of the rectangle-hit block: owns one on-screen object's position and velocity and drives its signed topLeftX/topLeftY.
- Updates once per video frame on startOfFrame, in fixed point, with gravity on Y.
- Applies edge bounces reported by the collision logic during the previous frame, plus an optional jump request.
- Clamps the object inside the visible screen.

Parameters:
- INITIAL_X, 280, reset top-left X in pixels.
- INITIAL_Y, 185, reset top-left Y in pixels.
- INITIAL_X_SPEED, 40, reset X speed in fixed-point units per frame (signed).
- INITIAL_Y_SPEED, 20, reset Y speed in fixed-point units per frame (signed).
- Y_ACCEL, 1, added to Y speed each frame (gravity).
- MAX_Y_SPEED, 230, Y speed saturation magnitude (applies to both signs).
- JUMP_SPEED, 200, magnitude of the upward speed loaded on a jump.
- FIXED_POINT_SHIFT, 6, fraction bits (1 pixel = 64 units).
- OBJECT_WIDTH_X, 32, object width in pixels.
- OBJECT_HEIGHT_Y, 16, object height in pixels.
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- collision  in  1  qualifies hitEdgeCode this cycle.
- hitEdgeCode  in  4  {top,right,bottom,left} sides of the object that were hit.
- jumpReq  in  1  one-cycle jump request.
- topLeftX  out  32 signed  integer pixel X.
- topLeftY  out  32 signed  integer pixel Y.

Behaviour:
- Reset (asynchronous, active low; resetN is the reset; clk is the only clock):
  - Positions = INITIAL_X<<FPS and INITIAL_Y<<FPS; speeds = INITIAL_X_SPEED and INITIAL_Y_SPEED.
  - topLeftX = INITIAL_X, topLeftY = INITIAL_Y.
  - hit latch and jump latch cleared; FSM = IDLE.
  - Reset asserted mid-update abandons the update and restores all of the above.
- Internal state: xPos, yPos, xSpd, ySpd, all signed 32-bit. topLeft outputs = arithmetic right shift by FIXED_POINT_SHIFT (floor).
- Latches, in IDLE only:
  - hitLatch |= hitEdgeCode whenever collision = 1.
  - jumpLatch set by jumpReq.
  - A collision or jump in the same cycle as startOfFrame goes into the next frame's latches, not the current update.
- FSM:
  - IDLE: on startOfFrame, snapshot the latches into working flags, clear the latches, go to MOVE.
  - MOVE (one cycle):
    - X: if (left hit and xSpd<0) or (right hit and xSpd>0), xSpd = -xSpd. Then xPos += new xSpd.
    - Y: if the jump flag is set, ySpd = -JUMP_SPEED. Otherwise, if (top hit and ySpd<0) or (bottom hit and ySpd>0), ySpd = -ySpd.
    - yPos += the resulting ySpd. After that, ySpd += Y_ACCEL, saturated to ±MAX_Y_SPEED.
    - Go to LIMIT.
  - LIMIT (one cycle):
    - xPos < 0: xPos = 0, xSpd = |xSpd|.
    - xPos > (SCREEN_W-OBJECT_WIDTH_X)<<FPS: xPos = that bound, xSpd = -|xSpd|.
    - Y handled the same way with bounds 0 and (SCREEN_H-OBJECT_HEIGHT_Y)<<FPS.
    - Register topLeftX/Y from the clamped values; go to IDLE.
- Latency: if edge E0 samples startOfFrame, outputs change at edge E2 and stay constant until the next frame's E2.
- startOfFrame seen while in MOVE or LIMIT is ignored.
- Opposing hit bits (left and right together) are legal: only the one matching the direction of motion flips the speed, so the speed flips at most once.

Decomposition:
- Shared package obj_pkg holds:
  - typedef fixed_t (signed 32-bit) and enum move_state_t {IDLE, MOVE, LIMIT};
  - constants FIXED_POINT_SHIFT, SCREEN_W, SCREEN_H;
  - edge bit indices EDGE_TOP=3, EDGE_RIGHT=2, EDGE_BOTTOM=1, EDGE_LEFT=0.
- One natural sub-module: axis_clamp. It is instantiated per axis, takes pos, spd, lo and hi, and returns the clamped pos and corrected spd.

Test Plan:
- Default reset, then 2 frames -> after frame 1: topLeftX=280 (xPos 17960), topLeftY=185 (yPos 11860), ySpd=21; after frame 2: topLeftX=281 (18000), topLeftY=185 (11881).
- Collision with hitEdgeCode=4'b0100 during frame 1, then frame 2 -> xSpd=-40, xPos=17920, topLeftX=280; 4'b0001 with xSpd=+40 -> no change.
- INITIAL_X=0, INITIAL_X_SPEED=-40 -> frame 1: topLeftX=0, xSpd=+40; frame 2: xPos=40, topLeftX=0; frame 3: xPos=80, topLeftX=1.
- jumpReq pulse, then frame -> ySpd used = -200, yPos=11640, topLeftY=181, ySpd becomes -199; 300 frames without hits -> ySpd never exceeds 230 and topLeftY is held at 464.
- Collision on the same cycle as startOfFrame -> not applied this frame, applied next frame.
- resetN low during MOVE -> outputs immediately return to 280/185 and FSM = IDLE.

Source files
------------

// File: rtl/obj_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : obj_pkg
//  Brief    : Shared types and constants for the on-screen object mover.
//  Revision : 1.0 - initial release
// ============================================================================
package obj_pkg;

    // Signed fixed-point value: position / speed in 1/64 pixel units
    typedef logic signed [31:0] fixed_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        LIMIT = 2'd2
    } move_state_t;

    localparam int FIXED_POINT_SHIFT = 6;
    localparam int SCREEN_W          = 640;
    localparam int SCREEN_H          = 480;

    // Bit positions inside hitEdgeCode
    localparam int EDGE_TOP    = 3;
    localparam int EDGE_RIGHT  = 2;
    localparam int EDGE_BOTTOM = 1;
    localparam int EDGE_LEFT   = 0;

endpackage
`default_nettype wire

// File: rtl/axis_clamp.sv
`default_nettype none
// ============================================================================
//  Module   : axis_clamp
//  Brief    : Keeps one axis position inside [lo, hi] and points the speed
//             back into the screen when a wall is crossed.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_clamp
    import obj_pkg::*;
(
    input  logic signed [31:0] i_pos,
    input  logic signed [31:0] i_spd,
    input  logic signed [31:0] i_lo,
    input  logic signed [31:0] i_hi,
    output logic signed [31:0] o_pos,
    output logic signed [31:0] o_spd
);

    fixed_t w_absSpd;

    // Clamp position; speed sign is forced toward the interior, not just negated
    always_comb begin
        w_absSpd = (i_spd < 0) ? -i_spd : i_spd;
        o_pos    = i_pos;
        o_spd    = i_spd;
        if (i_pos < i_lo) begin
            o_pos = i_lo;
            o_spd = w_absSpd;
        end else if (i_pos > i_hi) begin
            o_pos = i_hi;
            o_spd = -w_absSpd;
        end
    end

endmodule
`default_nettype wire

// File: rtl/obj_mover.sv
`default_nettype none
// ============================================================================
//  Module   : obj_mover
//  Brief    : Per-frame fixed-point position/velocity update of one object
//             with gravity, edge bounces, jump and screen clamping.
//  Revision : 1.0 - initial release
// ============================================================================
module obj_mover
    import obj_pkg::*;
#(
    parameter int INITIAL_X       = 280,
    parameter int INITIAL_Y       = 185,
    parameter int INITIAL_X_SPEED = 40,
    parameter int INITIAL_Y_SPEED = 20,
    parameter int Y_ACCEL         = 1,
    parameter int MAX_Y_SPEED     = 230,
    parameter int JUMP_SPEED      = 200,
    parameter int OBJECT_WIDTH_X  = 32,
    parameter int OBJECT_HEIGHT_Y = 16
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               collision,
    input  logic [3:0]         hitEdgeCode,
    input  logic               jumpReq,
    output logic signed [31:0] topLeftX,
    output logic signed [31:0] topLeftY
);

    localparam fixed_t c_X_RST  = INITIAL_X << FIXED_POINT_SHIFT;
    localparam fixed_t c_Y_RST  = INITIAL_Y << FIXED_POINT_SHIFT;
    localparam fixed_t c_X_HI   = (SCREEN_W - OBJECT_WIDTH_X) << FIXED_POINT_SHIFT;
    localparam fixed_t c_Y_HI   = (SCREEN_H - OBJECT_HEIGHT_Y) << FIXED_POINT_SHIFT;
    localparam fixed_t c_ZERO   = 0;
    localparam fixed_t c_JUMP   = JUMP_SPEED;
    localparam fixed_t c_ACCEL  = Y_ACCEL;
    localparam fixed_t c_MAX_Y  = MAX_Y_SPEED;

    move_state_t r_state, w_stateNext;
    fixed_t      r_xPos, r_yPos, r_xSpd, r_ySpd;
    logic [3:0]  r_hitLatch, r_hitFlags;
    logic        r_jumpLatch, r_jumpFlag;

    fixed_t      w_xSpdMove, w_xPosMove, w_ySpdUsed, w_yPosMove, w_ySpdSum, w_ySpdGrav;
    fixed_t      w_xPosLim, w_xSpdLim, w_yPosLim, w_ySpdLim;

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= IDLE;
        else         r_state <= w_stateNext;
    end

    // Next state: one MOVE and one LIMIT cycle per frame; frame pulses while busy are dropped
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (startOfFrame) w_stateNext = MOVE;
            MOVE:    w_stateNext = LIMIT;
            LIMIT:   w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // MOVE arithmetic: bounce only when the hit side matches the direction of travel
    always_comb begin
        w_xSpdMove = r_xSpd;
        if ((r_hitFlags[EDGE_LEFT] && r_xSpd < 0) || (r_hitFlags[EDGE_RIGHT] && r_xSpd > 0))
            w_xSpdMove = -r_xSpd;
        w_xPosMove = r_xPos + w_xSpdMove;

        w_ySpdUsed = r_ySpd;
        if (r_jumpFlag)
            w_ySpdUsed = -c_JUMP;
        else if ((r_hitFlags[EDGE_TOP] && r_ySpd < 0) || (r_hitFlags[EDGE_BOTTOM] && r_ySpd > 0))
            w_ySpdUsed = -r_ySpd;
        w_yPosMove = r_yPos + w_ySpdUsed;

        w_ySpdSum  = w_ySpdUsed + c_ACCEL;
        w_ySpdGrav = w_ySpdSum;
        if (w_ySpdSum > c_MAX_Y)
            w_ySpdGrav = c_MAX_Y;
        else if (w_ySpdSum < -c_MAX_Y)
            w_ySpdGrav = -c_MAX_Y;
    end

    axis_clamp u_clampX (
        .i_pos (r_xPos),
        .i_spd (r_xSpd),
        .i_lo  (c_ZERO),
        .i_hi  (c_X_HI),
        .o_pos (w_xPosLim),
        .o_spd (w_xSpdLim)
    );

    axis_clamp u_clampY (
        .i_pos (r_yPos),
        .i_spd (r_ySpd),
        .i_lo  (c_ZERO),
        .i_hi  (c_Y_HI),
        .o_pos (w_yPosLim),
        .o_spd (w_ySpdLim)
    );

    // Event latches, frame snapshot and per-state datapath updates
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_xPos      <= c_X_RST;
            r_yPos      <= c_Y_RST;
            r_xSpd      <= INITIAL_X_SPEED;
            r_ySpd      <= INITIAL_Y_SPEED;
            r_hitLatch  <= 4'b0000;
            r_jumpLatch <= 1'b0;
            r_hitFlags  <= 4'b0000;
            r_jumpFlag  <= 1'b0;
            topLeftX    <= INITIAL_X;
            topLeftY    <= INITIAL_Y;
        end else begin
            case (r_state)
                IDLE: begin
                    // Events arriving with startOfFrame belong to the following frame
                    r_hitLatch  <= (startOfFrame ? 4'b0000 : r_hitLatch)
                                 | (collision ? hitEdgeCode : 4'b0000);
                    r_jumpLatch <= (startOfFrame ? 1'b0 : r_jumpLatch) | jumpReq;
                    if (startOfFrame) begin
                        r_hitFlags <= r_hitLatch;
                        r_jumpFlag <= r_jumpLatch;
                    end
                end
                MOVE: begin
                    r_xSpd <= w_xSpdMove;
                    r_xPos <= w_xPosMove;
                    r_ySpd <= w_ySpdGrav;
                    r_yPos <= w_yPosMove;
                end
                LIMIT: begin
                    r_xPos   <= w_xPosLim;
                    r_xSpd   <= w_xSpdLim;
                    r_yPos   <= w_yPosLim;
                    r_ySpd   <= w_ySpdLim;
                    topLeftX <= w_xPosLim >>> FIXED_POINT_SHIFT;
                    topLeftY <= w_yPosLim >>> FIXED_POINT_SHIFT;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
